// File: rtl/detector_pkg.sv
// Shared constants and helpers for the detector event logging path.
// Imported by the FIFO, the logger and future statistics blocks.
package detector_pkg;

  localparam int TS_WIDTH_DEF  = 16;
  localparam int DEPTH_DEF     = 8;
  localparam int CNT_WIDTH_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

  // Counter of 'width' bits (<=32) held in the low bits; stops at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/detector_event_logger_if.sv
// Valid/ready read port carrying buffered event timestamps.
// master drives timestamps out, slave is the consumer.
interface detector_event_logger_if #(
  parameter int TS_WIDTH = 16
);
  logic                ev_valid;
  logic                ev_ready;
  logic [TS_WIDTH-1:0] ev_ts;

  modport master (output ev_valid, output ev_ts, input ev_ready);
  modport slave  (input ev_valid, input ev_ts, output ev_ready);
endinterface

// File: rtl/detector_event_logger_fifo.sv
// Synchronous FIFO; occupancy is tracked by a level register so pointers wrap freely.
// Caller must not push when full (unless popping) nor pop when empty.
module event_fifo
  import detector_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH),
  localparam int LW = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  // Storage carries data only and is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/detector_event_logger.sv
// Timestamps every cycle with w high, buffers the stamps in a FIFO and keeps
// saturating accepted/dropped counts plus a sticky overflow flag.
module detector_event_logger
  import detector_pkg::*;
#(
  parameter int TS_WIDTH  = TS_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w,
  input  logic                         clr_stats,
  detector_event_logger_if.master      ev,
  output logic [clog2(DEPTH):0]        level,
  output logic [CNT_WIDTH-1:0]         ev_count,
  output logic [CNT_WIDTH-1:0]         drop_count,
  output logic                         overflow
);

  logic [TS_WIDTH-1:0]  ts_q;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;
  logic [CNT_WIDTH-1:0] ev_count_q, drop_count_q;
  logic [CNT_WIDTH-1:0] ev_count_d, drop_count_d;
  logic                 overflow_q, overflow_d;

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_WIDTH'(1);
  end

  // A full FIFO still accepts when the consumer frees a slot this same edge.
  assign pop     = !empty & ev.ev_ready;
  assign push_ok = w & (!full | pop);
  assign drop    = w & full & !pop;

  event_fifo #(.WIDTH(TS_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .din   (ts_q),
    .dout  (ev.ev_ts),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign ev.ev_valid = !empty;

  // Clear applies first, then this cycle's increment lands on the cleared value.
  always_comb begin
    ev_count_d   = clr_stats ? '0 : ev_count_q;
    drop_count_d = clr_stats ? '0 : drop_count_q;
    overflow_d   = clr_stats ? 1'b0 : overflow_q;
    if (push_ok) ev_count_d = CNT_WIDTH'(sat_inc(32'(ev_count_d), CNT_WIDTH));
    if (drop) begin
      drop_count_d = CNT_WIDTH'(sat_inc(32'(drop_count_d), CNT_WIDTH));
      overflow_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_count_q   <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      ev_count_q   <= ev_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign ev_count   = ev_count_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_detector_event_logger.sv
// Directed bench for detector_event_logger: a default-sized instance plus a
// narrow one (4-bit timestamps, 2-bit counters) for wrap and saturation.
module tb_detector_event_logger;

  logic       clk = 1'b0;
  logic       reset;
  logic       w, clr_stats;
  logic [3:0] level;
  logic [7:0] ev_count, drop_count;
  logic       overflow;

  logic       w4, clr4;
  logic [3:0] level4;
  logic [1:0] ev_count4, drop4;
  logic       ovf4;

  int n_cmp = 0;
  int n_mis = 0;

  detector_event_logger_if #(.TS_WIDTH(16)) evif ();
  detector_event_logger_if #(.TS_WIDTH(4))  evif4 ();

  detector_event_logger dut (
    .clk        (clk),
    .reset      (reset),
    .w          (w),
    .clr_stats  (clr_stats),
    .ev         (evif),
    .level      (level),
    .ev_count   (ev_count),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  detector_event_logger #(.TS_WIDTH(4), .DEPTH(8), .CNT_WIDTH(2)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .w          (w4),
    .clr_stats  (clr4),
    .ev         (evif4),
    .level      (level4),
    .ev_count   (ev_count4),
    .drop_count (drop4),
    .overflow   (ovf4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle after the reset edge, where ts_q is 0.
  task automatic do_reset();
    reset = 1'b1;
    w = 1'b0; clr_stats = 1'b0; evif.ev_ready = 1'b0;
    w4 = 1'b0; clr4 = 1'b0; evif4.ev_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic [3:0] wrap_exp [4];

  initial begin
    wrap_exp[0] = 4'd15; wrap_exp[1] = 4'd0; wrap_exp[2] = 4'd1; wrap_exp[3] = 4'd2;

    // Reset state
    do_reset();
    chk("rst_valid", evif.ev_valid, 0);
    chk("rst_ts", evif.ev_ts, 0);
    chk("rst_level", level, 0);
    chk("rst_evcnt", ev_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ovf", overflow, 0);

    // Single event at ts 5
    repeat (5) step();
    w = 1'b1; step(); w = 1'b0;
    chk("single_valid", evif.ev_valid, 1);
    chk("single_ts", evif.ev_ts, 5);
    chk("single_level", level, 1);
    chk("single_evcnt", ev_count, 1);
    evif.ev_ready = 1'b1; step(); evif.ev_ready = 1'b0;
    chk("single_pop_valid", evif.ev_valid, 0);
    chk("single_pop_level", level, 0);

    // Overflow: ten events into eight slots, then drain
    do_reset();
    w = 1'b1; repeat (10) step(); w = 1'b0;
    chk("ovf_level", level, 8);
    chk("ovf_evcnt", ev_count, 8);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_flag", overflow, 1);
    evif.ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_valid", evif.ev_valid, 1);
      chk("ovf_drain_ts", evif.ev_ts, i);
      step();
    end
    evif.ev_ready = 1'b0;
    chk("ovf_empty_valid", evif.ev_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Full with simultaneous push and pop
    do_reset();
    w = 1'b1; repeat (8) step(); w = 1'b0;
    chk("fullpp_fill_level", level, 8);
    repeat (12) step();
    w = 1'b1; evif.ev_ready = 1'b1; step(); w = 1'b0;
    chk("fullpp_level", level, 8);
    chk("fullpp_drop", drop_count, 0);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_evcnt", ev_count, 9);
    for (int i = 0; i < 8; i++) begin
      chk("fullpp_ts", evif.ev_ts, (i < 7) ? i + 1 : 20);
      step();
    end
    evif.ev_ready = 1'b0;
    chk("fullpp_empty", evif.ev_valid, 0);

    // Timestamp wrap and counter saturation on the narrow instance
    do_reset();
    repeat (15) step();
    w4 = 1'b1; repeat (4) step(); w4 = 1'b0;
    chk("wrap_level", level4, 4);
    chk("wrap_evcnt_sat", ev_count4, 3);
    chk("wrap_drop", drop4, 0);
    chk("wrap_ovf", ovf4, 0);
    evif4.ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_ts", evif4.ev_ts, wrap_exp[i]);
      step();
    end
    evif4.ev_ready = 1'b0;
    chk("wrap_empty", evif4.ev_valid, 0);

    // Reset mid-operation
    do_reset();
    w = 1'b1; repeat (9) step(); w = 1'b0;
    evif.ev_ready = 1'b1; repeat (5) step(); evif.ev_ready = 1'b0;
    chk("midrst_pre_level", level, 3);
    chk("midrst_pre_drop", drop_count, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst_valid", evif.ev_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_evcnt", ev_count, 0);
    chk("midrst_drop", drop_count, 0);
    chk("midrst_ovf", overflow, 0);
    w = 1'b1; step(); w = 1'b0;
    chk("midrst_ts_restart", evif.ev_ts, 0);

    // Statistics clear with accepted event, then with a drop
    do_reset();
    w = 1'b1; repeat (4) step();
    chk("clr_pre_evcnt", ev_count, 4);
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    chk("clr_evcnt", ev_count, 1);
    chk("clr_drop", drop_count, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_level", level, 5);
    chk("clr_head_ts", evif.ev_ts, 0);
    repeat (3) step();
    chk("clr2_pre_evcnt", ev_count, 4);
    clr_stats = 1'b1; step(); clr_stats = 1'b0; w = 1'b0;
    chk("clr2_evcnt", ev_count, 0);
    chk("clr2_drop", drop_count, 1);
    chk("clr2_ovf", overflow, 1);
    chk("clr2_level", level, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
